amber_wb_responder: RTL and testbench

//  Synthesizable Wishbone responder (slave) for the Amber core's 128-bit instruction/data port.
//  - Answers core read cycles with instruction words pushed by the bench through a FIFO.
//  - Captures core write cycles (address, word, byte mask) into a result FIFO for the monitor.
//  - Replaces direct driving of i_wb_dat/i_wb_ack from the bench interface.

---
 rtl/amber_wb_pkg.sv | 29 ++
 rtl/amber_wb_fifo.sv | 55 +++++
 rtl/amber_wb_responder.sv | 198 +++++++++++++++++++
 tb/tb_amber_wb_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/amber_wb_pkg.sv
// Shared types and constants for the Amber Wishbone responder.
package amber_wb_pkg;

    // Core NOP, returned on unused read lanes and when no instruction is queued.
    localparam logic [31:0] FILL_WORD_DEF = 32'hF0801003;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_WR_WAIT = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  mask;
    } wb_res_t;

    // Builds a 128-bit read beat: FILL_WORD everywhere except the addressed lane.
    function automatic logic [127:0] lane_word(input logic [1:0] lane,
                                               input logic [31:0] word,
                                               input logic [31:0] fill);
        logic [127:0] v;
        v = {4{fill}};
        v[{lane, 5'd0} +: 32] = word;
        return v;
    endfunction

endpackage

// File: rtl/amber_wb_fifo.sv
// Generic synchronous FIFO. A pop on an empty FIFO is ignored; a push on a
// full FIFO is accepted only if a pop frees a slot in the same cycle.
module amber_wb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & ((r_count != L_FULL) | w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone responder for the Amber core's 128-bit port: reads are served from
// an instruction FIFO, writes are captured into a result FIFO.
// Optional: define AMBER_WB_RESP_ERR_EN to answer out-of-range addresses with wb_err.
//
// state    | meaning
// ST_IDLE  | waiting for wb_cyc & wb_stb
// ST_ACK   | wb_ack (or wb_err) high for this single cycle
// ST_WR_WAIT | write held off because the result FIFO is full
module amber_wb_responder
    import amber_wb_pkg::*;
#(
    parameter int          INST_DEPTH = 16,
    parameter int          RES_DEPTH  = 16,
    parameter logic [31:0] FILL_WORD  = FILL_WORD_DEF
`ifdef AMBER_WB_RESP_ERR_EN
    ,
    parameter logic [31:0] ADR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADR_HI     = 32'h0000_FFFF
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   wb_adr,
    input  logic [15:0]                   wb_sel,
    input  logic                          wb_we,
    input  logic [127:0]                  wb_dat_w,
    input  logic                          wb_cyc,
    input  logic                          wb_stb,
    output logic [127:0]                  wb_dat_r,
    output logic                          wb_ack,
    output logic                          wb_err,
    input  logic                          inst_valid,
    input  logic [31:0]                   inst_data,
    output logic                          inst_ready,
    output logic                          res_valid,
    output logic [31:0]                   res_adr,
    output logic [31:0]                   res_dat,
    output logic [3:0]                    res_mask,
    input  logic                          res_ready,
    output logic                          starve,
    output logic [$clog2(INST_DEPTH):0]   inst_count
);

    localparam int IAW = $clog2(INST_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [IAW:0] L_INST_FULL = (IAW + 1)'(INST_DEPTH);
    localparam logic [RAW:0] L_RES_FULL  = (RAW + 1)'(RES_DEPTH);

    wb_state_t    r_state;
    wb_state_t    w_state_nxt;
    logic [127:0] r_dat_r;
    logic [127:0] w_dat_nxt;
    logic         r_ack;
    logic         w_ack_nxt;
    logic         r_starve;
    logic         w_starve_nxt;
    logic         w_err_nxt;

    logic [1:0]   w_lane;
    logic         w_req;
    logic         w_adr_bad;
    logic         w_inst_push;
    logic         w_inst_pop;
    logic         w_inst_empty;
    logic [31:0]  w_inst_q;
    logic [RAW:0] w_res_count;
    logic         w_res_space;
    logic         w_res_push;
    wb_res_t      w_res_d;
    wb_res_t      w_res_q;

    assign w_lane       = wb_adr[3:2];
    assign w_req        = wb_cyc & wb_stb;
    assign w_inst_empty = (inst_count == '0);
    assign inst_ready   = (inst_count != L_INST_FULL);
    assign w_inst_push  = inst_valid & inst_ready;
    // A pop in the same cycle frees a slot, so a full result FIFO can still take the write.
    assign w_res_space  = (w_res_count != L_RES_FULL) | res_ready;

    assign w_res_d.adr  = wb_adr;
    assign w_res_d.dat  = wb_dat_w[{w_lane, 5'd0} +: 32];
    assign w_res_d.mask = wb_sel[{w_lane, 2'd0} +: 4];

    assign res_valid = (w_res_count != '0);
    assign res_adr   = w_res_q.adr;
    assign res_dat   = w_res_q.dat;
    assign res_mask  = w_res_q.mask;

    assign wb_dat_r = r_dat_r;
    assign wb_ack   = r_ack;
    assign starve   = r_starve;

`ifdef AMBER_WB_RESP_ERR_EN
    logic r_err;

    assign w_adr_bad = (wb_adr < ADR_LO) | (wb_adr > ADR_HI);
    assign wb_err    = r_err;

    // Error response register, mirrors the ack timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_err_nxt;
    end
`else
    assign w_adr_bad = 1'b0;
    assign wb_err    = 1'b0;
`endif

    amber_wb_fifo #(
        .WIDTH (32),
        .DEPTH (INST_DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_inst_push),
        .i_data  (inst_data),
        .i_pop   (w_inst_pop),
        .o_data  (w_inst_q),
        .o_count (inst_count)
    );

    amber_wb_fifo #(
        .WIDTH ($bits(wb_res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_res_push),
        .i_data  (w_res_d),
        .i_pop   (res_ready),
        .o_data  (w_res_q),
        .o_count (w_res_count)
    );

    // Next state, FIFO strobes and the registered response values.
    always_comb begin
        w_state_nxt  = r_state;
        w_dat_nxt    = r_dat_r;
        w_ack_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        w_starve_nxt = 1'b0;
        w_inst_pop   = 1'b0;
        w_res_push   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_adr_bad) begin
                        w_state_nxt = ST_ACK;
                        w_err_nxt   = 1'b1;
                    end else if (!wb_we) begin
                        w_state_nxt = ST_ACK;
                        w_ack_nxt   = 1'b1;
                        if (w_inst_empty) begin
                            w_dat_nxt    = {4{FILL_WORD}};
                            w_starve_nxt = 1'b1;
                        end else begin
                            w_dat_nxt  = lane_word(w_lane, w_inst_q, FILL_WORD);
                            w_inst_pop = 1'b1;
                        end
                    end else if (w_res_space) begin
                        w_state_nxt = ST_ACK;
                        w_ack_nxt   = 1'b1;
                        w_res_push  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WR_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (!wb_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_res_space) begin
                    w_state_nxt = ST_ACK;
                    w_ack_nxt   = 1'b1;
                    w_res_push  = 1'b1;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and response registers; reset drops any pending ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dat_r  <= {4{FILL_WORD}};
            r_ack    <= 1'b0;
            r_starve <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dat_r  <= w_dat_nxt;
            r_ack    <= w_ack_nxt;
            r_starve <= w_starve_nxt;
        end
    end

endmodule

// File: tb/tb_amber_wb_responder.sv
// Directed bench for amber_wb_responder; out-of-range check follows AMBER_WB_RESP_ERR_EN.
module tb_amber_wb_responder;

    localparam logic [31:0] F = 32'hF0801003;

    logic         clk;
    logic         rst_n;
    logic [31:0]  wb_adr;
    logic [15:0]  wb_sel;
    logic         wb_we;
    logic [127:0] wb_dat_w;
    logic         wb_cyc;
    logic         wb_stb;
    logic [127:0] wb_dat_r;
    logic         wb_ack;
    logic         wb_err;
    logic         inst_valid;
    logic [31:0]  inst_data;
    logic         inst_ready;
    logic         res_valid;
    logic [31:0]  res_adr;
    logic [31:0]  res_dat;
    logic [3:0]   res_mask;
    logic         res_ready;
    logic         starve;
    logic [4:0]   inst_count;

    int n_checks = 0;
    int n_pass   = 0;

    amber_wb_responder u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_adr     (wb_adr),
        .wb_sel     (wb_sel),
        .wb_we      (wb_we),
        .wb_dat_w   (wb_dat_w),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_dat_r   (wb_dat_r),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .res_valid  (res_valid),
        .res_adr    (res_adr),
        .res_dat    (res_dat),
        .res_mask   (res_mask),
        .res_ready  (res_ready),
        .starve     (starve),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input logic [31:0] adr);
        wb_adr = adr;
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
    endtask

    task automatic wr_req(input logic [31:0] adr, input logic [15:0] sel, input logic [127:0] dat);
        wb_adr   = adr;
        wb_sel   = sel;
        wb_dat_w = dat;
        wb_we    = 1'b1;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic push_inst(input logic [31:0] w);
        inst_valid = 1'b1;
        inst_data  = w;
        tick();
        inst_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_dat_w = '0;
        wb_cyc = 1'b0; wb_stb = 1'b0; inst_valid = 1'b0; inst_data = '0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_ack",        wb_ack, 0);
        chk("rst_err",        wb_err, 0);
        chk("rst_dat",        wb_dat_r, {4{F}});
        chk("rst_starve",     starve, 0);
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_res_valid",  res_valid, 0);
        chk("rst_inst_count", inst_count, 0);
        rst_n = 1'b1;
        tick();

        // Read lane 0 with one queued word
        push_inst(32'hE3A01005);
        chk("t1_count_pre", inst_count, 1);
        rd_req(32'h0);
        tick();
        chk("t1_ack",    wb_ack, 1);
        chk("t1_dat",    wb_dat_r, {F, F, F, 32'hE3A01005});
        chk("t1_count",  inst_count, 0);
        chk("t1_starve", starve, 0);
        bus_idle();
        tick();
        chk("t1_ack_off", wb_ack, 0);
        chk("t1_dat_hold", wb_dat_r, {F, F, F, 32'hE3A01005});

        // Starved read
        rd_req(32'h8);
        tick();
        chk("t2_ack",    wb_ack, 1);
        chk("t2_dat",    wb_dat_r, {4{F}});
        chk("t2_starve", starve, 1);
        bus_idle();
        tick();
        chk("t2_starve_off", starve, 0);
        chk("t2_ack_off",    wb_ack, 0);

        // Starved read coinciding with a push: word stays queued
        rd_req(32'h0);
        inst_valid = 1'b1; inst_data = 32'h77777777;
        tick();
        inst_valid = 1'b0;
        chk("t2b_dat",    wb_dat_r, {4{F}});
        chk("t2b_starve", starve, 1);
        chk("t2b_count",  inst_count, 1);
        bus_idle();
        tick();
        rd_req(32'h28);
        tick();
        chk("t2b_lane2", wb_dat_r, {F, 32'h77777777, F, F});
        bus_idle();
        tick();

        // Write capture on lane 1
        wr_req(32'h104, 16'h00F0, {32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h33333333});
        tick();
        chk("t3_ack",   wb_ack, 1);
        chk("t3_valid", res_valid, 1);
        chk("t3_adr",   res_adr, 32'h104);
        chk("t3_dat",   res_dat, 32'hDEADBEEF);
        chk("t3_mask",  res_mask, 4'hF);
        bus_idle();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t3_popped", res_valid, 0);

        // Instruction FIFO full, overflow dropped, push+pop keeps count
        for (int i = 0; i < 16; i++) push_inst(32'hA0000000 + i);
        chk("if_count_full", inst_count, 16);
        chk("if_ready_full", inst_ready, 0);
        push_inst(32'h00000BAD);
        chk("if_drop", inst_count, 16);
        rd_req(32'hC);
        inst_valid = 1'b1; inst_data = 32'h00000BAD;
        tick();
        inst_valid = 1'b0;
        chk("if_lane3", wb_dat_r, {32'hA0000000, F, F, F});
        chk("if_count_pop", inst_count, 15);
        bus_idle();
        tick();
        rd_req(32'h0);
        inst_valid = 1'b1; inst_data = 32'h0000C0C0;
        tick();
        inst_valid = 1'b0;
        chk("if_pushpop_dat",   wb_dat_r, {F, F, F, 32'hA0000001});
        chk("if_pushpop_count", inst_count, 15);
        bus_idle();
        tick();

        // Fill result FIFO, 17th write waits until one pop
        for (int i = 0; i < 16; i++) begin
            wr_req(32'h1000 + 32'(i) * 16, 16'h000F, {96'h0, 32'h50000000 + 32'(i)});
            tick();
            bus_idle();
            tick();
        end
        wr_req(32'h0FF0, 16'h0000, {96'h0, 32'h12345678});
        tick();
        chk("t4_wait_ack0", wb_ack, 0);
        tick();
        chk("t4_wait_ack1", wb_ack, 0);
        chk("t4_head", res_adr, 32'h1000);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t4_ack", wb_ack, 1);
        chk("t4_head2", res_adr, 32'h1010);
        bus_idle();
        tick();
        chk("t4_ack_off", wb_ack, 0);
        for (int i = 1; i < 16; i++) begin
            chk("t4_drain_adr", res_adr, 32'h1000 + 32'(i) * 16);
            chk("t4_drain_dat", res_dat, 32'h50000000 + 32'(i));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        chk("t4_last_adr",  res_adr, 32'h0FF0);
        chk("t4_last_dat",  res_dat, 32'h12345678);
        chk("t4_last_mask", res_mask, 4'h0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t4_empty", res_valid, 0);

        // Reset during ACK
        wr_req(32'h20, 16'hFFFF, {4{32'hCAFEF00D}});
        tick();
        bus_idle();
        tick();
        chk("t5_res_pre", res_valid, 1);
        rd_req(32'h0);
        tick();
        chk("t5_ack_pre", wb_ack, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_ack",        wb_ack, 0);
        chk("t5_inst_ready", inst_ready, 1);
        chk("t5_res_valid",  res_valid, 0);
        chk("t5_count",      inst_count, 0);
        chk("t5_dat",        wb_dat_r, {4{F}});
        bus_idle();
        tick();
        rst_n = 1'b1;
        tick();

        // Out-of-range address
        push_inst(32'h13579BDF);
        rd_req(32'h0002_0000);
        tick();
`ifdef AMBER_WB_RESP_ERR_EN
        chk("t6_err",   wb_err, 1);
        chk("t6_ack",   wb_ack, 0);
        chk("t6_count", inst_count, 1);
`else
        chk("t6_err",   wb_err, 0);
        chk("t6_ack",   wb_ack, 1);
        chk("t6_dat",   wb_dat_r, {4{F}} ^ {96'h0, F ^ 32'h13579BDF});
        chk("t6_count", inst_count, 0);
`endif
        bus_idle();
        tick();
        chk("t6_err_off", wb_err, 0);
        chk("t6_ack_off", wb_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
